// File: rtl/debug_frame_serializer_pkg.sv
// Shared debug-unit constants: controller IDs, bus widths and the capture FSM encoding.
package debug_frame_serializer_pkg;

   localparam int DBG_NB_BYTE          = 8;
   localparam int DBG_NB_CONTROL_FRAME = 32;
   localparam int DBG_NB_ID            = 6;

   localparam logic [DBG_NB_ID-1:0] DBG_IDLE_ID      = 6'b111111;
   localparam logic [DBG_NB_ID-1:0] DBG_MEMORY_ID    = 6'b000000;
   localparam logic [DBG_NB_ID-1:0] DBG_REGISTERS_ID = 6'b000001;
   localparam logic [DBG_NB_ID-1:0] DBG_LATCHES_ID   = 6'b000010;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQUEST,
      ST_CAPTURE,
      ST_RELEASE
   } capture_state_t;

endpackage

// File: rtl/debug_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO only lands if a pop frees a slot.
module debug_sync_fifo
   import debug_frame_serializer_pkg::*;
#(
   parameter int NB_DATA    = DBG_NB_CONTROL_FRAME,
   parameter int LOG2_DEPTH = 3
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_push,
   input  logic               i_pop,
   input  logic [NB_DATA-1:0] i_data,
   output logic [NB_DATA-1:0] o_data,
   output logic               o_full,
   output logic               o_empty
);

   localparam int DEPTH = 2**LOG2_DEPTH;

   logic [NB_DATA-1:0]    mem [DEPTH];
   logic [LOG2_DEPTH-1:0] wr_ptr;
   logic [LOG2_DEPTH-1:0] rd_ptr;
   logic [LOG2_DEPTH:0]   count;
   logic                  do_push;
   logic                  do_pop;

   assign o_full  = (count == (LOG2_DEPTH+1)'(DEPTH));
   assign o_empty = (count == '0);
   assign do_pop  = i_pop && !o_empty;
   assign do_push = i_push && (!o_full || do_pop);
   assign o_data  = mem[rd_ptr];

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; pointers and count define what is valid.
   always_ff @(posedge i_clock) begin
      if (do_push) mem[wr_ptr] <= i_data;
   end

endmodule

// File: rtl/debug_frame_serializer.sv
// Requests frames from one debug controller, buffers them and streams them to the UART MSB-first.
module debug_frame_serializer
   import debug_frame_serializer_pkg::*;
#(
   parameter int                     NB_CONTROL_FRAME = DBG_NB_CONTROL_FRAME,
   parameter int                     NB_BYTE          = DBG_NB_BYTE,
   parameter int                     LOG2_FIFO_DEPTH  = 3,
   parameter int                     NB_TIMEOUT       = 5,
   parameter logic [DBG_NB_ID-1:0]   IDLE_ID          = DBG_IDLE_ID
) (
   input  logic                        i_clock,
   input  logic                        i_reset,
   input  logic                        i_start,
   input  logic [DBG_NB_ID-1:0]        i_controller_id,
   output logic [DBG_NB_ID-1:0]        o_request_select,
   input  logic [NB_CONTROL_FRAME-1:0] i_frame,
   input  logic                        i_writing,
   output logic [NB_BYTE-1:0]          o_tx_data,
   output logic                        o_tx_valid,
   input  logic                        i_tx_ready,
   output logic                        o_busy,
   output logic                        o_overflow,
   output logic                        o_timeout
);

   localparam int NB_BYTES_PER_FRAME = NB_CONTROL_FRAME / NB_BYTE;
   localparam int NB_INDEX           = (NB_BYTES_PER_FRAME > 1) ? $clog2(NB_BYTES_PER_FRAME) : 1;
   localparam logic [NB_INDEX-1:0] LAST_INDEX = NB_INDEX'(NB_BYTES_PER_FRAME - 1);

   capture_state_t              state_q, state_d;
   logic [DBG_NB_ID-1:0]        id_q, id_d;
   logic [DBG_NB_ID-1:0]        select_q, select_d;
   logic [NB_TIMEOUT-1:0]       tmo_cnt_q, tmo_cnt_d;
   logic                        timeout_q, timeout_d;
   logic                        overflow_q, overflow_d;
   logic                        start_accept;
   logic                        push;

   logic [NB_CONTROL_FRAME-1:0] shift_q, shift_d;
   logic [NB_INDEX-1:0]         idx_q, idx_d;
   logic                        valid_q, valid_d;
   logic                        pop;

   logic [NB_CONTROL_FRAME-1:0] fifo_data;
   logic                        fifo_full;
   logic                        fifo_empty;

   debug_sync_fifo #(
      .NB_DATA    (NB_CONTROL_FRAME),
      .LOG2_DEPTH (LOG2_FIFO_DEPTH)
   ) u_fifo (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_push  (push),
      .i_pop   (pop),
      .i_data  (i_frame),
      .o_data  (fifo_data),
      .o_full  (fifo_full),
      .o_empty (fifo_empty)
   );

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q    <= ST_IDLE;
         id_q       <= IDLE_ID;
         select_q   <= IDLE_ID;
         tmo_cnt_q  <= '0;
         timeout_q  <= 1'b0;
         overflow_q <= 1'b0;
         shift_q    <= '0;
         idx_q      <= '0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         id_q       <= id_d;
         select_q   <= select_d;
         tmo_cnt_q  <= tmo_cnt_d;
         timeout_q  <= timeout_d;
         overflow_q <= overflow_d;
         shift_q    <= shift_d;
         idx_q      <= idx_d;
         valid_q    <= valid_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      id_d         = id_q;
      tmo_cnt_d    = tmo_cnt_q;
      timeout_d    = timeout_q;
      start_accept = 1'b0;
      push         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            tmo_cnt_d = '0;
            if (i_start) begin
               start_accept = 1'b1;
               id_d         = i_controller_id;
               timeout_d    = 1'b0;
               state_d      = ST_REQUEST;
            end
         end
         ST_REQUEST: begin
            // Timeout fires on the cycle the count would reach all-ones: 2**NB_TIMEOUT-1 cycles waited.
            tmo_cnt_d = tmo_cnt_q + 1'b1;
            if (i_writing) begin
               push    = 1'b1;
               state_d = ST_CAPTURE;
            end else if (tmo_cnt_d == '1) begin
               timeout_d = 1'b1;
               state_d   = ST_RELEASE;
            end
         end
         ST_CAPTURE: begin
            if (i_writing) push = 1'b1;
            else           state_d = ST_RELEASE;
         end
         ST_RELEASE: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
      select_d = (state_d == ST_REQUEST || state_d == ST_CAPTURE) ? id_d : IDLE_ID;
   end

   always_comb begin
      overflow_d = overflow_q;
      if (start_accept)                      overflow_d = 1'b0;
      else if (push && fifo_full && !pop)    overflow_d = 1'b1;
   end

   // Reloading on the last byte's transfer keeps o_tx_valid continuous across words.
   always_comb begin
      shift_d = shift_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      pop     = 1'b0;
      if (!valid_q) begin
         if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_data;
            idx_d   = '0;
            valid_d = 1'b1;
         end
      end else if (i_tx_ready) begin
         if (idx_q == LAST_INDEX) begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = fifo_data;
               idx_d   = '0;
            end else begin
               shift_d = '0;
               idx_d   = '0;
               valid_d = 1'b0;
            end
         end else begin
            shift_d = shift_q << NB_BYTE;
            idx_d   = idx_q + 1'b1;
         end
      end
   end

   assign o_request_select = select_q;
   assign o_tx_data        = shift_q[NB_CONTROL_FRAME-1 -: NB_BYTE];
   assign o_tx_valid       = valid_q;
   assign o_busy           = (state_q != ST_IDLE) || !fifo_empty || valid_q;
   assign o_overflow       = overflow_q;
   assign o_timeout        = timeout_q;

endmodule

// File: tb/tb_debug_frame_serializer.sv
// Bench for debug_frame_serializer: queue-based byte-stream model plus directed and random scenarios.
module tb_debug_frame_serializer;

   localparam logic [5:0] IDLE = 6'h3F;
   localparam int         DEPTH = 8;

   logic        i_clock = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_start = 1'b0;
   logic [5:0]  i_controller_id = '0;
   logic [31:0] i_frame = '0;
   logic        i_writing = 1'b0;
   logic        i_tx_ready = 1'b1;
   logic [5:0]  o_request_select;
   logic [7:0]  o_tx_data;
   logic        o_tx_valid;
   logic        o_busy;
   logic        o_overflow;
   logic        o_timeout;

   debug_frame_serializer dut (
      .i_clock          (i_clock),
      .i_reset          (i_reset),
      .i_start          (i_start),
      .i_controller_id  (i_controller_id),
      .o_request_select (o_request_select),
      .i_frame          (i_frame),
      .i_writing        (i_writing),
      .o_tx_data        (o_tx_data),
      .o_tx_valid       (o_tx_valid),
      .i_tx_ready       (i_tx_ready),
      .o_busy           (o_busy),
      .o_overflow       (o_overflow),
      .o_timeout        (o_timeout)
   );

   always #5 i_clock = ~i_clock;

   int          errors = 0;
   int          checks = 0;
   int          xfer_count = 0;
   int          hold_checks = 0;
   int          run_cur = 0;
   int          run_max = 0;
   int          ready_mode = 0;
   int          bp_cyc = 0;
   logic [3:0]  bp_pat = 4'b1001;
   logic [7:0]  exp_q[$];
   logic [31:0] mq[$];
   logic [31:0] stim_q[$];
   int          m_rem = 0;
   logic        m_ovf = 1'b0;

   // Reference: frames accepted into an 8-deep buffer become four bytes each, MSB first.
   // A word leaves the buffer once the previous word's bytes are all sent.
   function automatic void model_step();
      if (i_reset) begin
         mq.delete(); exp_q.delete(); m_rem = 0; m_ovf = 1'b0;
         return;
      end
      if (i_start) m_ovf = 1'b0;
      if (m_rem > 0 && i_tx_ready) m_rem--;
      if (m_rem == 0 && mq.size() > 0) begin
         void'(mq.pop_front());
         m_rem = 4;
      end
      if (i_writing) begin
         if (mq.size() < DEPTH) begin
            mq.push_back(i_frame);
            for (int b = 3; b >= 0; b--) exp_q.push_back(i_frame[b*8 +: 8]);
         end else m_ovf = 1'b1;
      end
   endfunction

   task automatic tick();
      @(posedge i_clock);
      model_step();
      #1;
      if (ready_mode == 1) begin
         bp_cyc++;
         i_tx_ready = bp_pat[bp_cyc[1:0]];
      end else if (ready_mode == 2) begin
         i_tx_ready = 1'($urandom_range(0, 1));
      end
      if (o_tx_valid) run_cur++; else run_cur = 0;
      if (run_cur > run_max) run_max = run_cur;
   endtask

   // Transfer monitor: every accepted byte must match the model, and a stalled byte must not move.
   logic       hold = 1'b0;
   logic [7:0] held = '0;
   always @(negedge i_clock) begin
      logic [7:0] e;
      if (i_reset) hold = 1'b0;
      else begin
         if (hold) begin
            checks++; hold_checks++;
            if (o_tx_valid !== 1'b1 || o_tx_data !== held) begin
               errors++;
               $display("FAIL stall_stable: valid=%b data=%h required valid=1 data=%h", o_tx_valid, o_tx_data, held);
            end
         end
         if (o_tx_valid && i_tx_ready) begin
            checks++; xfer_count++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL byte_unexpected: got %h required no transfer", o_tx_data);
            end else begin
               e = exp_q.pop_front();
               if (o_tx_data !== e) begin
                  errors++;
                  $display("FAIL byte_order: got %h required %h", o_tx_data, e);
               end
            end
         end
         hold = o_tx_valid && !i_tx_ready;
         held = o_tx_data;
      end
   end

   task automatic start_req(input logic [5:0] id);
      i_controller_id = id;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
   endtask

   task automatic drive_frames();
      for (int i = 0; i < stim_q.size(); i++) begin
         i_writing = 1'b1;
         i_frame = stim_q[i];
         tick();
      end
      i_writing = 1'b0;
      tick();
   endtask

   task automatic drain(output int n);
      n = 0;
      while (o_busy && n < 400) begin
         tick();
         n++;
      end
      checks++;
      if (o_busy) begin
         errors++;
         $display("FAIL drain_bound: busy still %b after %0d cycles required 0", o_busy, n);
      end
   endtask

   task automatic test_reset();
      i_reset = 1'b1;
      tick(); tick();
      checks += 6;
      if (o_request_select !== IDLE) begin errors++; $display("FAIL reset_select: got %h required %h", o_request_select, IDLE); end
      if (o_tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", o_tx_valid); end
      if (o_tx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h required 00", o_tx_data); end
      if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", o_busy); end
      if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b required 0", o_overflow); end
      if (o_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b required 0", o_timeout); end
      i_reset = 1'b0;
      tick();
   endtask

   task automatic test_memory_read();
      int x0, n;
      x0 = xfer_count; run_max = 0;
      start_req(6'b000000);
      checks++;
      if (o_request_select !== 6'h00) begin errors++; $display("FAIL mem_select_c1: got %h required 00", o_request_select); end
      i_writing = 1'b1; i_frame = 32'hDEADBEEF;
      tick();
      checks++;
      if (o_request_select !== 6'h00) begin errors++; $display("FAIL mem_select_c2: got %h required 00", o_request_select); end
      i_writing = 1'b0;
      tick();
      checks += 3;
      if (o_request_select !== IDLE) begin errors++; $display("FAIL mem_release: got %h required %h", o_request_select, IDLE); end
      if (o_tx_valid !== 1'b1) begin errors++; $display("FAIL mem_first_valid: got %b required 1", o_tx_valid); end
      if (o_tx_data !== 8'hDE) begin errors++; $display("FAIL mem_first_byte: got %h required DE", o_tx_data); end
      drain(n);
      checks += 3;
      if (n !== 4) begin errors++; $display("FAIL mem_busy_fall: got %0d cycles required 4", n); end
      if (xfer_count - x0 !== 4) begin errors++; $display("FAIL mem_count: got %0d bytes required 4", xfer_count - x0); end
      if (run_max !== 4) begin errors++; $display("FAIL mem_consecutive: got run %0d required 4", run_max); end
   endtask

   task automatic test_backpressure();
      int x0, h0, n;
      x0 = xfer_count; h0 = hold_checks;
      bp_cyc = 0; i_tx_ready = 1'b1; ready_mode = 1;
      start_req(6'b000000);
      stim_q = {32'hDEADBEEF};
      drive_frames();
      drain(n);
      ready_mode = 0; i_tx_ready = 1'b1;
      checks += 3;
      if (xfer_count - x0 !== 4) begin errors++; $display("FAIL bp_count: got %0d bytes required 4", xfer_count - x0); end
      if (hold_checks == h0) begin errors++; $display("FAIL bp_no_stall: got %0d stalls required >0", hold_checks - h0); end
      if (exp_q.size() !== 0) begin errors++; $display("FAIL bp_leftover: got %0d bytes pending required 0", exp_q.size()); end
   endtask

   task automatic test_back_to_back();
      int x0, n;
      x0 = xfer_count; run_max = 0;
      start_req(6'b000001);
      stim_q = {32'h1, 32'h2, 32'h3};
      drive_frames();
      drain(n);
      checks += 2;
      if (xfer_count - x0 !== 12) begin errors++; $display("FAIL burst_count: got %0d bytes required 12", xfer_count - x0); end
      if (run_max !== 12) begin errors++; $display("FAIL burst_gap: got valid run %0d required 12", run_max); end
   endtask

   task automatic test_overflow();
      int x0, pend, n;
      x0 = xfer_count;
      i_tx_ready = 1'b0;
      start_req(6'b000010);
      stim_q.delete();
      for (int i = 0; i < 10; i++) stim_q.push_back(32'(i));
      drive_frames();
      tick();
      pend = exp_q.size();
      checks += 3;
      if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b required 1", o_overflow); end
      if (o_overflow !== m_ovf) begin errors++; $display("FAIL ovf_model: got %b required %b", o_overflow, m_ovf); end
      if (pend != 32 && pend != 36) begin errors++; $display("FAIL ovf_accepted: got %0d bytes required 32 or 36", pend); end
      i_tx_ready = 1'b1;
      drain(n);
      checks += 2;
      if (xfer_count - x0 !== pend) begin errors++; $display("FAIL ovf_count: got %0d bytes required %0d", xfer_count - x0, pend); end
      if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b required 1", o_overflow); end
   endtask

   task automatic test_timeout();
      int x0;
      x0 = xfer_count;
      start_req(6'b000101);
      checks++;
      if (o_overflow !== 1'b0) begin errors++; $display("FAIL tmo_clears_ovf: got %b required 0", o_overflow); end
      for (int c = 0; c < 31; c++) begin
         checks++;
         if (o_request_select !== 6'h05 || o_timeout !== 1'b0) begin
            errors++;
            $display("FAIL tmo_wait c%0d: select=%h timeout=%b required select=05 timeout=0", c, o_request_select, o_timeout);
         end
         tick();
      end
      checks += 2;
      if (o_request_select !== IDLE) begin errors++; $display("FAIL tmo_release: got %h required %h", o_request_select, IDLE); end
      if (o_timeout !== 1'b1) begin errors++; $display("FAIL tmo_flag: got %b required 1", o_timeout); end
      tick();
      checks += 3;
      if (o_busy !== 1'b0) begin errors++; $display("FAIL tmo_idle_busy: got %b required 0", o_busy); end
      if (o_timeout !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b required 1", o_timeout); end
      if (xfer_count !== x0) begin errors++; $display("FAIL tmo_no_bytes: got %0d bytes required 0", xfer_count - x0); end
      start_req(6'b000000);
      checks++;
      if (o_timeout !== 1'b0) begin errors++; $display("FAIL tmo_clear: got %b required 0", o_timeout); end
   endtask

   // Continues the request opened at the end of test_timeout.
   task automatic test_reset_mid_byte();
      int x0;
      x0 = xfer_count;
      i_tx_ready = 1'b1;
      stim_q = {32'hA1B2C3D4};
      drive_frames();
      tick(); tick();
      i_tx_ready = 1'b0;
      #2;
      checks++;
      if (o_tx_data !== 8'hC3 || o_tx_valid !== 1'b1) begin errors++; $display("FAIL rst_pending: data=%h valid=%b required C3/1", o_tx_data, o_tx_valid); end
      i_reset = 1'b1;
      tick();
      checks += 3;
      if (o_tx_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", o_tx_valid); end
      if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", o_busy); end
      if (o_request_select !== IDLE) begin errors++; $display("FAIL rst_select: got %h required %h", o_request_select, IDLE); end
      i_reset = 1'b0; i_tx_ready = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      checks++;
      if (xfer_count - x0 !== 2) begin errors++; $display("FAIL rst_flush: got %0d bytes required 2", xfer_count - x0); end
   endtask

   task automatic test_random();
      logic [5:0] ids [3];
      logic [5:0] id;
      int nfr, n;
      ids[0] = 6'b000000; ids[1] = 6'b000001; ids[2] = 6'b000010;
      ready_mode = 2;
      for (int r = 0; r < 6; r++) begin
         id = ids[$urandom_range(0, 2)];
         nfr = $urandom_range(1, 11);
         stim_q.delete();
         for (int i = 0; i < nfr; i++) stim_q.push_back($urandom);
         start_req(id);
         checks++;
         if (o_request_select !== id) begin errors++; $display("FAIL rnd_select r%0d: got %h required %h", r, o_request_select, id); end
         drive_frames();
         drain(n);
         checks += 2;
         if (o_overflow !== m_ovf) begin errors++; $display("FAIL rnd_overflow r%0d: got %b required %b", r, o_overflow, m_ovf); end
         if (exp_q.size() !== 0) begin errors++; $display("FAIL rnd_leftover r%0d: got %0d bytes required 0", r, exp_q.size()); end
      end
      ready_mode = 0; i_tx_ready = 1'b1;
   endtask

   initial begin
      test_reset();
      test_memory_read();
      test_backpressure();
      test_back_to_back();
      test_overflow();
      test_timeout();
      test_reset_mid_byte();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: simulation still running at %0t required finish", $time);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule
